// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - core-to-RAM bridge with memory-mapped UART TX FIFO, LED/switch and cycle counter page
module mem_io_bridge #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [14:0] IO_BASE      = 15'h3FF0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [14:0] i_cpu_addr,
   input  logic [15:0] i_cpu_wdata,
   input  logic        i_cpu_write,
   output logic [15:0] o_cpu_rdata,
   output logic [14:0] o_ram_addr,
   output logic [15:0] o_ram_wdata,
   output logic        o_ram_we,
   input  logic [15:0] i_ram_rdata,
   input  logic [7:0]  i_sw,
   output logic [7:0]  o_led,
   output logic        o_uart_tx
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  PTR_MASK  = 3'(FIFO_DEPTH - 1);
   localparam logic [3:0]  FIFO_FULL = 4'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic        w_io_hit;
   logic [3:0]  w_off;
   logic        w_io_wr;
   logic [15:0] w_io_rd;
   logic        w_empty;
   logic        w_full;
   logic        w_busy;
   logic        w_push_req;
   logic        w_push;
   logic        w_pop;

   logic        r_io_sel;
   logic [15:0] r_io_rdata;
   logic [7:0]  r_led;
   logic [15:0] r_cycle;

   logic [7:0]  r_fifo [0:7];
   logic [2:0]  r_wptr;
   logic [2:0]  r_rptr;
   logic [3:0]  r_count;
   logic        r_overflow;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_timer;
   logic [15:0] w_timer_nxt;
   logic [3:0]  r_bit_idx;
   logic [3:0]  w_bit_nxt;
   logic [7:0]  r_shift;
   logic [7:0]  w_shift_nxt;
   logic        r_tx;
   logic        w_tx_nxt;
   logic        w_timer_done;

   assign w_io_hit    = (i_cpu_addr[14:4] == IO_BASE[14:4]);
   assign w_off       = i_cpu_addr[3:0];
   assign w_io_wr     = i_cpu_write && w_io_hit;

   assign o_ram_addr  = i_cpu_addr;
   assign o_ram_wdata = i_cpu_wdata;
   assign o_ram_we    = i_cpu_write && !w_io_hit;
   assign o_cpu_rdata = r_io_sel ? r_io_rdata : i_ram_rdata;
   assign o_led       = r_led;
   assign o_uart_tx   = r_tx;

   assign w_empty     = (r_count == 4'd0);
   assign w_full      = (r_count == FIFO_FULL);
   assign w_busy      = (r_state != S_IDLE);
   // A push against a full FIFO is dropped even when the UART pops in the same cycle.
   assign w_push_req  = w_io_wr && (w_off == 4'h0);
   assign w_push      = w_push_req && !w_full;

   always_comb begin
      w_io_rd = 16'h0000;
      case (w_off)
         4'h1:    w_io_rd = {8'h00, r_count, r_overflow, w_busy, w_full, w_empty};
         4'h2:    w_io_rd = {i_sw, r_led};
         4'h3:    w_io_rd = r_cycle;
         default: w_io_rd = 16'h0000;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_io_sel   <= 1'b0;
         r_io_rdata <= 16'h0000;
      end else begin
         r_io_sel   <= w_io_hit;
         r_io_rdata <= w_io_rd;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_led   <= 8'h00;
         r_cycle <= 16'h0000;
      end else begin
         if (w_io_wr && (w_off == 4'h2))
            r_led <= i_cpu_wdata[7:0];
         if (w_io_wr && (w_off == 4'h3))
            r_cycle <= i_cpu_wdata;
         else
            r_cycle <= r_cycle + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_fifo[r_wptr] <= i_cpu_wdata[7:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr     <= 3'd0;
         r_rptr     <= 3'd0;
         r_count    <= 4'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wptr <= (r_wptr + 3'd1) & PTR_MASK;
         if (w_pop)
            r_rptr <= (r_rptr + 3'd1) & PTR_MASK;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
         if (w_push_req && w_full)
            r_overflow <= 1'b1;
         else if (w_io_wr && (w_off == 4'h1) && i_cpu_wdata[3])
            r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_timer   <= 16'd0;
         r_bit_idx <= 4'd0;
         r_shift   <= 8'h00;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_bit_idx <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_tx_nxt;
      end
   end

   assign w_timer_done = (r_timer == BIT_LAST);

   // uart_tx is registered, so each state's line level is loaded on the edge that enters it.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_bit_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_fifo[r_rptr];
               w_timer_nxt = 16'd0;
               w_tx_nxt    = 1'b0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_timer_done) begin
               w_timer_nxt = 16'd0;
               w_bit_nxt   = 4'd0;
               w_tx_nxt    = r_shift[0];
               w_state_nxt = S_DATA;
            end else begin
               w_timer_nxt = r_timer + 16'd1;
            end
         end
         S_DATA: begin
            if (w_timer_done) begin
               w_timer_nxt = 16'd0;
               if (r_bit_idx == 4'd7) begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt   = r_bit_idx + 4'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_timer_nxt = r_timer + 16'd1;
            end
         end
         S_STOP: begin
            if (w_timer_done) begin
               w_timer_nxt = 16'd0;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + 16'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - scoreboard bench for mem_io_bridge (RAM path, I/O page, UART frames, FIFO overflow, reset)
module tb_mem_io_bridge;

   localparam int CPB = 4;
   localparam logic [14:0] A_TX   = 15'h3FF0;
   localparam logic [14:0] A_STAT = 15'h3FF1;
   localparam logic [14:0] A_LED  = 15'h3FF2;
   localparam logic [14:0] A_CYC  = 15'h3FF3;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_write;
   logic [15:0] cpu_rdata;
   logic [14:0] ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_we;
   logic [15:0] ram_rdata;
   logic [7:0]  sw;
   logic [7:0]  led;
   logic        uart_tx;

   logic [15:0] ram_mem [0:32767];
   logic [15:0] rq [$];
   string       rtag [$];
   logic [7:0]  uq [$];
   logic        rd_req = 1'b0;
   logic        rd_pipe = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          rx_frames = 0;
   int          rst_cnt = 0;
   int          f0;

   always #5 clk = ~clk;

   mem_io_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .IO_BASE(15'h3FF0)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .i_cpu_write(cpu_write),
      .o_cpu_rdata(cpu_rdata),
      .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we),
      .i_ram_rdata(ram_rdata),
      .i_sw(sw), .o_led(led), .o_uart_tx(uart_tx)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) ram_mem[i] = 16'h0000;
      ram_rdata = 16'h0000;
   end

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
      rd_pipe   <= rd_req;
      if (rst) rst_cnt <= rst_cnt + 1;
   end

   always @(negedge clk) begin
      if (rd_pipe && rq.size() != 0)
         check(rtag.pop_front(), cpu_rdata, rq.pop_front());
   end

   // UART receiver: samples mid-bit; frames overlapping a reset are discarded.
   initial begin : uart_mon
      int         mon_rc;
      logic [9:0] mon_bits;
      logic [7:0] mon_exp;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            mon_rc      = rst_cnt;
            mon_bits[0] = 1'b0;
            for (int k = 1; k < 10; k++) begin
               repeat (CPB) @(negedge clk);
               mon_bits[k] = uart_tx;
            end
            if (mon_rc == rst_cnt) begin
               rx_frames++;
               check("uart_expected_frame", 16'(uq.size() != 0), 16'd1);
               if (uq.size() != 0) begin
                  mon_exp = uq.pop_front();
                  check("uart_byte", {8'h00, mon_bits[8:1]}, {8'h00, mon_exp});
               end
               check("uart_stop", 16'(mon_bits[9]), 16'd1);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [14:0] a, input logic [15:0] d);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_write = 1'b1;
      @(posedge clk);
      #1;
      cpu_write = 1'b0;
      cpu_addr  = 15'h0000;
   endtask

   task automatic rd(input logic [14:0] a, input logic [15:0] exp, input string tag);
      cpu_addr  = a;
      cpu_write = 1'b0;
      rd_req    = 1'b1;
      rq.push_back(exp);
      rtag.push_back(tag);
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic wait_uart();
      for (int i = 0; i < 2000; i++) begin
         if (uq.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("uart_drain", 16'(uq.size()), 16'd0);
   endtask

   initial begin
      rst = 1'b1; cpu_addr = 15'h0000; cpu_wdata = 16'h0000; cpu_write = 1'b0; sw = 8'h3C;
      idle(3);
      check("rst_tx", 16'(uart_tx), 16'd1);
      check("rst_led", 16'(led), 16'h0000);
      check("rst_rdata", cpu_rdata, 16'h0000);
      rst = 1'b0;
      rd(A_STAT, 16'h0001, "rst_status");

      cpu_addr = 15'h2500; cpu_wdata = 16'h1234; cpu_write = 1'b1;
      #1 check("ram_we_ram", 16'(ram_we), 16'd1);
      @(posedge clk); #1;
      cpu_write = 1'b0;
      rd(15'h2500, 16'h1234, "ram_read");

      cpu_addr = A_LED; cpu_wdata = 16'h00A5; cpu_write = 1'b1;
      #1 check("ram_we_io", 16'(ram_we), 16'd0);
      @(posedge clk); #1;
      cpu_write = 1'b0;
      check("led_write", 16'(led), 16'h00A5);
      rd(A_LED, 16'h3CA5, "led_read");

      wr(A_CYC, 16'hFFFE);
      idle(1);
      rd(A_CYC, 16'hFFFF, "cyc_0");
      rd(A_CYC, 16'h0000, "cyc_1");
      rd(A_CYC, 16'h0001, "cyc_2");

      wr(A_TX, 16'h0055);
      uq.push_back(8'h55);
      idle(1);
      check("tx_start", 16'(uart_tx), 16'd0);
      rd(A_STAT, 16'h0005, "status_busy");
      wait_uart();
      idle(6);
      rd(A_STAT, 16'h0001, "status_idle");

      f0 = rx_frames;
      for (int i = 0; i < 10; i++) begin
         wr(A_TX, 16'(8'h10 + i));
         if (i < 9) uq.push_back(8'(8'h10 + i));
      end
      rd(A_STAT, 16'h008E, "status_full");
      wr(A_STAT, 16'h0008);
      rd(A_STAT, 16'h0086, "status_ovf_clr");
      wait_uart();
      idle(6);
      check("frames_9", 16'(rx_frames - f0), 16'd9);
      rd(A_STAT, 16'h0001, "status_drained");

      wr(A_LED, 16'h00FF);
      wr(A_TX, 16'h00A1);
      wr(A_TX, 16'h00B2);
      wr(A_TX, 16'h00C3);
      for (int i = 0; i < 100; i++) begin
         if (uart_tx === 1'b0) break;
         @(posedge clk);
         #1;
      end
      check("mid_start", 16'(uart_tx), 16'd0);
      idle(16);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("rst_mid_tx", 16'(uart_tx), 16'd1);
      f0 = rx_frames;
      rd(A_STAT, 16'h0001, "rst_mid_status");
      check("rst_mid_led", 16'(led), 16'h0000);
      idle(100);
      check("rst_mid_tx_idle", 16'(uart_tx), 16'd1);
      check("rst_mid_frames", 16'(rx_frames - f0), 16'd0);

      idle(2);
      check("rd_q_empty", 16'(rq.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
